// File: rtl/random_cell_placer_pkg.sv
// Shared types and helpers for the random cell placer.
package placer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } placer_state_t;

  function automatic int idx_w(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/random_cell_placer_if.sv
// Control, random input and occupancy-map bundle of the random cell placer.
interface random_cell_placer_if
  import placer_pkg::*;
#(
    parameter int CELLS = 16
);

    localparam int IDX_W = idx_w(CELLS);
    localparam int CNT_W = $clog2(CELLS + 1);

    logic             start;
    logic [IDX_W-1:0] random_number;
    logic             busy;
    logic             done;
    logic [CELLS-1:0] occupied;
    logic [CNT_W-1:0] place_count;
    logic [IDX_W-1:0] probe_idx;
    logic             probe_hit;

    modport master (
        output start,
        output random_number,
        output probe_idx,
        input  busy,
        input  done,
        input  occupied,
        input  place_count,
        input  probe_hit
    );

    modport slave (
        input  start,
        input  random_number,
        input  probe_idx,
        output busy,
        output done,
        output occupied,
        output place_count,
        output probe_hit
    );

endinterface

// File: rtl/random_cell_placer_free_cell_finder.sv
// Priority encoder returning the lowest-index free cell of an occupancy map.
module free_cell_finder
  import placer_pkg::*;
#(
    parameter int CELLS = 16,
    localparam int IDX_W = idx_w(CELLS)
) (
    input  logic [CELLS-1:0] occupied,
    output logic [IDX_W-1:0] free_idx,
    output logic             any_free
);

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/random_cell_placer.sv
// Places ITEMS distinct markers on a CELLS board from a random index stream.
// Define PLACER_FALLBACK_EN to force lowest-free placement after MAX_TRIES rejects.
module random_cell_placer
  import placer_pkg::*;
#(
    parameter int CELLS     = 16,
    parameter int ITEMS     = 4,
    parameter int MAX_TRIES = 8
) (
    input logic                clk,
    input logic                rst,
    random_cell_placer_if.slave bus
);

    localparam int IDX_W = idx_w(CELLS);
    localparam int CNT_W = $clog2(CELLS + 1);

    placer_state_t    state_q, state_d;
    logic [CELLS-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cand_free;
    logic             place;
    logic [IDX_W-1:0] place_idx;

    // Decoded compare keeps out-of-range candidates rejected for any CELLS.
    always_comb begin
        cand_free = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (bus.random_number == IDX_W'(i))
                cand_free = ~occ_q[i];
        end
    end

    always_comb begin
        bus.probe_hit = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (bus.probe_idx == IDX_W'(i))
                bus.probe_hit = occ_q[i];
        end
    end

`ifdef PLACER_FALLBACK_EN
    localparam int RW = $clog2(MAX_TRIES + 1);

    logic [RW-1:0]    rej_q, rej_d;
    logic [IDX_W-1:0] free_idx;
    logic             any_free;

    free_cell_finder #(
        .CELLS(CELLS)
    ) u_finder (
        .occupied(occ_q),
        .free_idx(free_idx),
        .any_free(any_free)
    );
`endif

    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        cnt_d     = cnt_q;
        place     = 1'b0;
        place_idx = bus.random_number;
`ifdef PLACER_FALLBACK_EN
        rej_d     = rej_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = FILL;
                    occ_d   = '0;
                    cnt_d   = '0;
                end
            end
            FILL: begin
`ifdef PLACER_FALLBACK_EN
                if (rej_q == RW'(MAX_TRIES) && any_free) begin
                    place     = 1'b1;
                    place_idx = free_idx;
                    rej_d     = '0;
                end else if (cand_free) begin
                    place = 1'b1;
                    rej_d = '0;
                end else begin
                    rej_d = rej_q + RW'(1);
                end
`else
                place = cand_free;
`endif
                if (place) begin
                    occ_d = occ_q | (CELLS'(1) << place_idx);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == CNT_W'(ITEMS))
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef PLACER_FALLBACK_EN
        if (state_d != FILL)
            rej_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            occ_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PLACER_FALLBACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rej_q <= '0;
        else
            rej_q <= rej_d;
    end
`endif

    assign bus.busy        = (state_q == FILL);
    assign bus.done        = (state_q == DONE);
    assign bus.occupied    = occ_q;
    assign bus.place_count = cnt_q;

endmodule

// File: tb/tb_random_cell_placer.sv
// Directed vector bench for random_cell_placer on 16-, 12- and 4-cell boards.
module tb_random_cell_placer;

    typedef struct {
        logic [3:0]  rn;
        logic [15:0] occ;
        int          cnt;
        logic        busy;
        logic        done;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    random_cell_placer_if #(.CELLS(16)) i16 ();
    random_cell_placer_if #(.CELLS(12)) i12 ();
    random_cell_placer_if #(.CELLS(4))  i4 ();

    random_cell_placer #(.CELLS(16), .ITEMS(4), .MAX_TRIES(8)) u16 (
        .clk(clk), .rst(rst), .bus(i16.slave)
    );
    random_cell_placer #(.CELLS(12), .ITEMS(4), .MAX_TRIES(8)) u12 (
        .clk(clk), .rst(rst), .bus(i12.slave)
    );
    random_cell_placer #(.CELLS(4), .ITEMS(4), .MAX_TRIES(8)) u4 (
        .clk(clk), .rst(rst), .bus(i4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t uniq[6];
    vec_t full[5];
    vec_t rst16[1];

    initial begin
        errors = 0;
        checks = 0;
        uniq[0] = '{4'd3,  16'h0008, 1, 1'b1, 1'b0};
        uniq[1] = '{4'd3,  16'h0008, 1, 1'b1, 1'b0};
        uniq[2] = '{4'd7,  16'h0088, 2, 1'b1, 1'b0};
        uniq[3] = '{4'd3,  16'h0088, 2, 1'b1, 1'b0};
        uniq[4] = '{4'd12, 16'h1088, 3, 1'b1, 1'b0};
        uniq[5] = '{4'd0,  16'h1089, 4, 1'b0, 1'b1};
        full[0] = '{4'd0, 16'h0001, 1, 1'b1, 1'b0};
        full[1] = '{4'd1, 16'h0003, 2, 1'b1, 1'b0};
        full[2] = '{4'd1, 16'h0003, 2, 1'b1, 1'b0};
        full[3] = '{4'd2, 16'h0007, 3, 1'b1, 1'b0};
        full[4] = '{4'd3, 16'h000F, 4, 1'b0, 1'b1};
        rst16[0] = '{4'd9, 16'h0200, 1, 1'b1, 1'b0};

        rst = 1'b0;
        i16.start = 0; i16.random_number = '0; i16.probe_idx = '0;
        i12.start = 0; i12.random_number = '0; i12.probe_idx = '0;
        i4.start  = 0; i4.random_number  = '0; i4.probe_idx  = '0;
        #12;
        chk("reset_occ", 32'(i16.occupied), 0);
        chk("reset_busy", 32'(i16.busy), 0);
        rst = 1'b1;

        // reset during activity
        i16.start = 1;
        step();
        i16.start = 0;
        i16.random_number = rst16[0].rn;
        step();
        chk("pre_rst_occ", 32'(i16.occupied), 32'(rst16[0].occ));
        #2 rst = 1'b0;
        #1;
        chk("rst_occ", 32'(i16.occupied), 0);
        chk("rst_cnt", 32'(i16.place_count), 0);
        chk("rst_busy", 32'(i16.busy), 0);
        chk("rst_done", 32'(i16.done), 0);
        rst = 1'b1;
        step();
        chk("idle_busy", 32'(i16.busy), 0);

        // unique placement with duplicates
        i16.start = 1;
        step();
        i16.start = 0;
        chk("start_busy", 32'(i16.busy), 1);
        chk("start_occ", 32'(i16.occupied), 0);
        for (int k = 0; k < 6; k++) begin
            i16.random_number = uniq[k].rn;
            step();
            chk($sformatf("uniq%0d_occ", k), 32'(i16.occupied),
                32'(uniq[k].occ));
            chk($sformatf("uniq%0d_cnt", k), 32'(i16.place_count),
                32'(uniq[k].cnt));
            chk($sformatf("uniq%0d_busy", k), 32'(i16.busy),
                32'(uniq[k].busy));
            chk($sformatf("uniq%0d_done", k), 32'(i16.done),
                32'(uniq[k].done));
        end
        i16.probe_idx = 4'd12;
        #1 chk("probe12", 32'(i16.probe_hit), 1);
        i16.probe_idx = 4'd1;
        #1 chk("probe1", 32'(i16.probe_hit), 0);
        i16.random_number = 4'd5;
        step();
        chk("hold_occ", 32'(i16.occupied), 32'h1089);
        chk("hold_done", 32'(i16.done), 1);

        // back-to-back restart from DONE
        i16.start = 1;
        step();
        i16.start = 0;
        chk("restart_occ", 32'(i16.occupied), 0);
        chk("restart_done", 32'(i16.done), 0);
        chk("restart_busy", 32'(i16.busy), 1);
        chk("restart_cnt", 32'(i16.place_count), 0);
        for (int k = 0; k < 4; k++) begin
            i16.random_number = 4'(5 + k);
            step();
        end
        chk("second_occ", 32'(i16.occupied), 32'h01E0);
        chk("second_done", 32'(i16.done), 1);

        // range reject on 12-cell board
        i12.start = 1;
        step();
        i12.start = 0;
        i12.random_number = 4'd13;
        step();
        i12.random_number = 4'd15;
        step();
        i12.random_number = 4'd2;
        step();
        chk("range_occ", 32'(i12.occupied), 32'h004);
        chk("range_cnt", 32'(i12.place_count), 1);
        i12.probe_idx = 4'd13;
        #1 chk("probe_oor", 32'(i12.probe_hit), 0);
        i12.probe_idx = 4'd2;
        #1 chk("probe2", 32'(i12.probe_hit), 1);

        // async abort mid-FILL
        #2 rst = 1'b0;
        #1;
        chk("abort_occ", 32'(i12.occupied), 0);
        chk("abort_busy", 32'(i12.busy), 0);
        chk("abort_cnt", 32'(i12.place_count), 0);
        rst = 1'b1;
        step();
        chk("abort_idle", 32'(i12.busy), 0);

        // full board
        i4.start = 1;
        step();
        i4.start = 0;
        for (int k = 0; k < 5; k++) begin
            i4.random_number = 2'(full[k].rn);
            step();
            chk($sformatf("full%0d_occ", k), 32'(i4.occupied),
                32'(full[k].occ));
            chk($sformatf("full%0d_cnt", k), 32'(i4.place_count),
                32'(full[k].cnt));
            chk($sformatf("full%0d_done", k), 32'(i4.done),
                32'(full[k].done));
        end

        // stuck candidate: fallback or endless FILL
        i16.start = 1;
        step();
        i16.start = 0;
        i16.random_number = 4'd5;
        step();
        chk("stuck_first", 32'(i16.occupied), 32'h0020);
        for (int k = 0; k < 8; k++) step();
        chk("stuck_8rej", 32'(i16.occupied), 32'h0020);
        step();
`ifdef PLACER_FALLBACK_EN
        chk("fallback_occ", 32'(i16.occupied), 32'h0021);
        chk("fallback_cnt", 32'(i16.place_count), 2);
`else
        chk("nofb_occ", 32'(i16.occupied), 32'h0020);
        for (int k = 0; k < 20; k++) step();
        chk("nofb_busy", 32'(i16.busy), 1);
        chk("nofb_cnt", 32'(i16.place_count), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/random_cell_placer.md
Name: random_cell_placer

Overview:
- Consumes the LFSR random-number stream and places ITEMS distinct markers (mines/targets) on a CELLS-cell game board.
- Rejects candidates that are out of range or duplicates; accepts one candidate per cycle.
- Exposes the resulting occupancy map to the game logic and display logic.
- Sits directly downstream of the random number generator and upstream of the board controller.

Parameters:
- CELLS, 16, number of board cells; index width IDX_W = $clog2(CELLS).
- ITEMS, 4, markers to place; legal range 1..CELLS.
- MAX_TRIES, 8, consecutive rejects before fallback; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request a new placement; sampled on rising clk.
- random_number  input  IDX_W  candidate index from the generator, which advances every clk.
- busy  output  1  high while placement is in progress.
- done  output  1  high while a completed board is held.
- occupied  output  CELLS  occupancy map; bit i set means a marker is at cell i.
- place_count  output  $clog2(CELLS+1)  number of markers placed so far.
- probe_idx  input  IDX_W  cell query index.
- probe_hit  output  1  combinational, equals occupied[probe_idx]; 0 if probe_idx >= CELLS.

Behaviour:
- Reset: rst low clears everything asynchronously.
  - occupied=0, place_count=0, busy=0, done=0, state=IDLE, reject counter=0.
- States: IDLE, FILL, DONE. All outputs are registered except probe_hit.
- IDLE:
  - start=1 moves to FILL on the next edge; occupied and place_count clear on that same edge; busy=1 from the following cycle.
- FILL, at each rising edge, with candidate r = random_number:
  - Accept when r < CELLS and occupied[r]==0: set occupied[r] and increment place_count.
  - Otherwise reject: no change.
  - If the accept brings place_count to ITEMS, move to DONE on the same edge: busy=0, done=1 next cycle.
  - start is ignored in FILL.
- DONE:
  - Hold occupied and place_count.
  - start=1 clears the map and count, drops done and re-enters FILL on the same edge. This is a back-to-back restart.
- Latency:
  - Best case ITEMS cycles from the first FILL edge to done.
  - No upper bound without the optional feature.
- ITEMS==CELLS: the board fills completely; the final accept needs the single remaining free index.
- Async reset mid-FILL aborts placement and returns to IDLE with a cleared map.
- place_count never exceeds ITEMS; occupied never has more than ITEMS bits set.

Optional Feature:
- Macro: PLACER_FALLBACK_EN.
- Defined:
  - A reject counter increments on each reject in FILL and clears on accept or on leaving FILL.
  - When the counter reaches MAX_TRIES, the next edge places a marker at the lowest-index free cell, ignoring random_number, then clears the counter.
  - This guarantees termination within ITEMS*(MAX_TRIES+1) cycles.
- Undefined:
  - The counter and finder are absent; placement relies solely on random candidates.

Decomposition:
- placer_pkg holds:
  - typedef enum logic [1:0] {IDLE, FILL, DONE} placer_state_t.
  - Helper function idx_w(cells) returning $clog2(cells).
- One sub-module: free_cell_finder.
  - Priority encoder: occupied map in, lowest free index and any_free flag out.
  - Instantiated only under PLACER_FALLBACK_EN.

Test Plan:
- Reset: drive rst=0 during activity, release → occupied=0, place_count=0, busy=0, done=0.
- Unique placement: CELLS=16, ITEMS=4, start, feed 3,3,7,3,12,0 on successive FILL edges.
  - Expected: occupied=16'h1088 after the 5th edge, then 16'h1089.
  - done=1 after the 6th edge; place_count=4; duplicates rejected.
- Range reject: CELLS=12, feed 13,15,2 → only bit 2 set; place_count=1.
- Restart from DONE: after done, pulse start.
  - Expected: occupied=0 and done=0 next cycle, busy=1, new placement proceeds.
- Full board: CELLS=4, ITEMS=4, feed 0,1,1,2,3 → occupied=4'hF, done=1, place_count=4.
- Fallback (PLACER_FALLBACK_EN, MAX_TRIES=8): hold random_number=5 with occupied[5]=1.
  - Expected: after 8 rejects the next edge sets the lowest free bit (bit 0).
  - Without the macro, busy stays high indefinitely.
